dram_local_arb: RTL and testbench

- Two-port arbiter and sequencer in front of the Altera DDR3 controller local interface, in the ddr_clk domain.
- Requester 0 is the Wishbone bridge command FIFO; requester 1 is a secondary master (DMA/video).
- Issues one 256-bit, size-1 local burst at a time, with round-robin fairness.
- Tracks outstanding reads in order, so each local_rdata_valid beat is steered to the requester that issued the read.

---
 rtl/dram_pkg.sv | 23 ++
 rtl/dram_tag_fifo.sv | 53 +++++
 rtl/dram_local_arb.sv | 181 ++++++++++++++++++
 tb/tb_dram_local_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared constants and types for the DDR3 local-interface arbiter.
package dram_pkg;

  localparam int         LOCAL_AW   = 24;
  localparam int         LOCAL_DW   = 256;
  localparam int         LOCAL_BEW  = 32;
  localparam logic [2:0] LOCAL_SIZE = 3'b001;

  // Requester id: 0 = Wishbone bridge FIFO, 1 = secondary master.
  typedef logic req_id_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2
  } arb_state_e;

  // The round-robin pointer always moves to the requester not just served.
  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/dram_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding read.
// Supports push and pop on the same edge; pop from empty is ignored.
module dram_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     ddr_clk,
  input  logic                     wb_rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge ddr_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge ddr_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dram_local_arb.sv
// Two-port round-robin arbiter/sequencer in front of the DDR3 controller
// local interface. One size-1 burst in flight at a time; read returns are
// steered back to their issuer through an in-order tag FIFO.
module dram_local_arb
  import dram_pkg::*;
#(
  parameter int MAX_RD = 4,
  parameter int AW     = LOCAL_AW
) (
  input  logic                 ddr_clk,
  input  logic                 wb_rst_i,
  input  logic                 init_done,
  input  logic                 r0_req,
  input  logic                 r0_we,
  input  logic [AW-1:0]        r0_addr,
  input  logic [LOCAL_DW-1:0]  r0_wdata,
  input  logic [LOCAL_BEW-1:0] r0_be,
  output logic                 r0_ack,
  output logic                 r0_rvalid,
  input  logic                 r1_req,
  input  logic                 r1_we,
  input  logic [AW-1:0]        r1_addr,
  input  logic [LOCAL_DW-1:0]  r1_wdata,
  input  logic [LOCAL_BEW-1:0] r1_be,
  output logic                 r1_ack,
  output logic                 r1_rvalid,
  output logic [LOCAL_DW-1:0]  rdata,
  input  logic                 local_ready,
  output logic [AW-1:0]        local_address,
  output logic                 local_burstbegin,
  output logic                 local_read_req,
  output logic                 local_write_req,
  output logic [LOCAL_DW-1:0]  local_wdata,
  output logic [LOCAL_BEW-1:0] local_be,
  output logic [2:0]           local_size,
  input  logic                 local_rdata_valid,
  input  logic [LOCAL_DW-1:0]  local_rdata,
  output logic                 busy,
  output logic                 err_orphan
);
  localparam int CW = $clog2(MAX_RD) + 1;

  arb_state_e           state_q, state_d;
  req_id_t              rr_ptr_q, cur_id_q, sel, tag_out;
  logic [CW-1:0]        rd_cnt, rd_cnt_d;
  logic                 tag_empty;
  logic                 elig0, elig1, pick, issue_done, push, pop, orphan;
  logic                 sel_we;
  logic [AW-1:0]        sel_addr;
  logic [LOCAL_DW-1:0]  sel_wdata;
  logic [LOCAL_BEW-1:0] sel_be;

  logic                 r0_ack_q, r1_ack_q, r0_rvalid_q, r1_rvalid_q;
  logic                 burst_q, rd_req_q, wr_req_q, busy_q, err_orphan_q;
  logic [AW-1:0]        addr_q;
  logic [LOCAL_DW-1:0]  wdata_q, rdata_q;
  logic [LOCAL_BEW-1:0] be_q;

  assign r0_ack           = r0_ack_q;
  assign r1_ack           = r1_ack_q;
  assign r0_rvalid        = r0_rvalid_q;
  assign r1_rvalid        = r1_rvalid_q;
  assign rdata            = rdata_q;
  assign local_address    = addr_q;
  assign local_burstbegin = burst_q;
  assign local_read_req   = rd_req_q;
  assign local_write_req  = wr_req_q;
  assign local_wdata      = wdata_q;
  assign local_be         = be_q;
  assign local_size       = LOCAL_SIZE;
  assign busy             = busy_q;
  assign err_orphan       = err_orphan_q;

  // Outstanding-read tags, in issue order.
  dram_tag_fifo #(.DEPTH(MAX_RD), .WIDTH(1)) u_tag_fifo (
    .ddr_clk  (ddr_clk),
    .wb_rst_i (wb_rst_i),
    .push_i   (push),
    .din_i    (cur_id_q),
    .pop_i    (pop),
    .dout_o   (tag_out),
    .empty_o  (tag_empty),
    .count_o  (rd_cnt)
  );

  // Eligibility and round-robin pick; writes bypass the read-credit limit.
  always_comb begin
    elig0      = r0_req && (r0_we || (rd_cnt < CW'(MAX_RD)));
    elig1      = r1_req && (r1_we || (rd_cnt < CW'(MAX_RD)));
    pick       = (state_q == ST_IDLE) && init_done && (elig0 || elig1);
    sel        = (elig0 && elig1) ? rr_ptr_q : req_id_t'(elig1);
    sel_we     = sel ? r1_we    : r0_we;
    sel_addr   = sel ? r1_addr  : r0_addr;
    sel_wdata  = sel ? r1_wdata : r0_wdata;
    sel_be     = sel ? r1_be    : r0_be;
    issue_done = (state_q == ST_ISSUE) && local_ready;
    push       = issue_done && rd_req_q;
    pop        = local_rdata_valid && !tag_empty;
    orphan     = local_rdata_valid && tag_empty;
  end

  // Next state; a dropped init_done is honoured only once the bus is idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_done) state_d = ST_IDLE;
      ST_IDLE:  if (!init_done) state_d = ST_INIT;
                else if (pick) state_d = ST_ISSUE;
      ST_ISSUE: if (local_ready) state_d = init_done ? ST_IDLE : ST_INIT;
      default:  state_d = ST_INIT;
    endcase
  end

  // Read-credit count after this edge, used to register busy.
  always_comb begin
    rd_cnt_d = rd_cnt;
    if (push && !pop)      rd_cnt_d = rd_cnt + CW'(1);
    else if (pop && !push) rd_cnt_d = rd_cnt - CW'(1);
  end

  // FSM, fairness pointer, owner of the in-flight command, busy flag.
  always_ff @(posedge ddr_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_INIT;
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE) || (rd_cnt_d != '0);
      if (pick) begin
        rr_ptr_q <= other_req(sel);
        cur_id_q <= sel;
      end
    end
  end

  // Command register toward the controller plus the one-cycle acks.
  always_ff @(posedge ddr_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      burst_q  <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      r0_ack_q <= pick && !sel;
      r1_ack_q <= pick && sel;
      burst_q  <= pick;
      if (pick) begin
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        be_q     <= sel_be;
        wr_req_q <= sel_we;
        rd_req_q <= !sel_we;
      end else if (issue_done) begin
        wr_req_q <= 1'b0;
        rd_req_q <= 1'b0;
      end
    end
  end

  // Read return: capture data, steer rvalid by tag, flag beats with no owner.
  always_ff @(posedge ddr_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rdata_q      <= '0;
      r0_rvalid_q  <= 1'b0;
      r1_rvalid_q  <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      if (local_rdata_valid) rdata_q <= local_rdata;
      r0_rvalid_q <= pop && (tag_out == 1'b0);
      r1_rvalid_q <= pop && (tag_out == 1'b1);
      if (orphan) err_orphan_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_local_arb.sv
// Bench for dram_local_arb: directed bring-up and reset/orphan cases around a
// long randomized run checked against a transaction-level model.
module tb_dram_local_arb;
  import dram_pkg::*;

  localparam int MAX_RD = 4;
  localparam int AW     = 24;

  logic                 ddr_clk = 1'b0;
  logic                 wb_rst_i, init_done;
  logic                 r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0]        r0_addr, r1_addr;
  logic [LOCAL_DW-1:0]  r0_wdata, r1_wdata;
  logic [LOCAL_BEW-1:0] r0_be, r1_be;
  logic                 r0_ack, r1_ack, r0_rvalid, r1_rvalid;
  logic [LOCAL_DW-1:0]  rdata;
  logic                 local_ready;
  logic [AW-1:0]        local_address;
  logic                 local_burstbegin, local_read_req, local_write_req;
  logic [LOCAL_DW-1:0]  local_wdata;
  logic [LOCAL_BEW-1:0] local_be;
  logic [2:0]           local_size;
  logic                 local_rdata_valid;
  logic [LOCAL_DW-1:0]  local_rdata;
  logic                 busy, err_orphan;

  dram_local_arb #(.MAX_RD(MAX_RD), .AW(AW)) dut (
    .ddr_clk(ddr_clk), .wb_rst_i(wb_rst_i), .init_done(init_done),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_be(r0_be), .r0_ack(r0_ack), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_be(r1_be), .r1_ack(r1_ack), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .local_ready(local_ready), .local_address(local_address),
    .local_burstbegin(local_burstbegin), .local_read_req(local_read_req),
    .local_write_req(local_write_req), .local_wdata(local_wdata),
    .local_be(local_be), .local_size(local_size),
    .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 ddr_clk = ~ddr_clk;

  typedef struct packed {
    logic                 id;
    logic                 we;
    logic [AW-1:0]        addr;
    logic [LOCAL_DW-1:0]  wdata;
    logic [LOCAL_BEW-1:0] be;
  } cmd_t;

  int   n_chk = 0;
  int   n_err = 0;
  cmd_t cur [2];
  bit   act [2];
  cmd_t exp_q [$];    // acked, not yet taken by the controller, in ack order
  logic ret_q [$];    // owners of reads taken by the controller, in order
  int   last_gnt;
  bit   prev_lreq;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic new_cmd(input int n);
    cur[n].id    = 1'(n);
    cur[n].we    = ($urandom_range(0, 9) < 4);
    cur[n].addr  = AW'($urandom);
    cur[n].wdata = rnd256();
    cur[n].be    = $urandom;
  endtask

  task automatic drive_req();
    r0_req = act[0]; r0_we = cur[0].we; r0_addr = cur[0].addr;
    r0_wdata = cur[0].wdata; r0_be = cur[0].be;
    r1_req = act[1]; r1_we = cur[1].we; r1_addr = cur[1].addr;
    r1_wdata = cur[1].wdata; r1_be = cur[1].be;
  endtask

  // Random traffic; gen=0 stops new commands and lets everything drain.
  task automatic run_model(input int ncyc, input bit gen);
    int             rdy_pct, vld_pct;
    bit             e [2];
    bit             lreq, acc, rv_exp;
    logic           rv_id;
    logic [255:0]   rv_dat;
    logic           ack [2];
    cmd_t           h;
    rdy_pct = 100; vld_pct = 50; rv_exp = 0; rv_id = 0; rv_dat = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (c % 50 == 0) begin
        rdy_pct = !gen ? 100 : ($urandom_range(0, 2) == 0 ? 0 : 70);
        vld_pct = !gen ? 60 : $urandom_range(5, 40);
      end
      // drive this cycle's inputs
      for (int n = 0; n < 2; n++)
        if (!act[n] && gen && $urandom_range(0, 99) < 40) begin
          new_cmd(n);
          act[n] = 1;
        end
      drive_req();
      local_ready       = ($urandom_range(0, 99) < rdy_pct);
      local_rdata_valid = (ret_q.size() > 0) && ($urandom_range(0, 99) < vld_pct);
      local_rdata       = rnd256();
      // controller-side view of the current command
      lreq = local_read_req || local_write_req;
      chk("rd_and_wr", local_read_req && local_write_req, 0);
      chk("burstbegin", local_burstbegin, lreq && !prev_lreq);
      prev_lreq = lreq;
      if (lreq) begin
        chk("cmd_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          chk("local_address", local_address, h.addr);
          chk("local_wdata", local_wdata, h.wdata);
          chk("local_be", local_be, h.be);
          chk("local_write_req", local_write_req, h.we);
        end
      end
      // what the coming edge does, from pre-edge inputs
      for (int n = 0; n < 2; n++) e[n] = act[n] && (cur[n].we || ret_q.size() < MAX_RD);
      acc = lreq && local_ready;
      if (local_rdata_valid) begin
        rv_exp = 1;
        rv_id  = ret_q.pop_front();
        rv_dat = local_rdata;
      end
      if (acc && exp_q.size() != 0) begin
        h = exp_q.pop_front();
        if (!h.we) ret_q.push_back(h.id);
      end
      tick();
      chk("r0_rvalid", r0_rvalid, rv_exp && rv_id == 1'b0);
      chk("r1_rvalid", r1_rvalid, rv_exp && rv_id == 1'b1);
      if (rv_exp) chk("rdata", rdata, rv_dat);
      rv_exp = 0;
      ack[0] = r0_ack; ack[1] = r1_ack;
      chk("dual_ack", ack[0] && ack[1], 0);
      for (int n = 0; n < 2; n++)
        if (ack[n]) begin
          chk($sformatf("ack%0d_eligible", n), e[n], 1);
          if (e[0] && e[1]) chk($sformatf("ack%0d_rr", n), n, 1 - last_gnt);
          exp_q.push_back(cur[n]);
          last_gnt = n;
          act[n]   = 0;
        end
      chk("busy", busy, local_read_req || local_write_req || ret_q.size() != 0);
      chk("err_orphan", err_orphan, 0);
    end
  endtask

  logic [255:0] a5;

  initial begin
    a5 = {32{8'hA5}};
    wb_rst_i = 1; init_done = 0; local_ready = 0;
    local_rdata_valid = 0; local_rdata = '0;
    act[0] = 0; act[1] = 0;
    cur[0] = '0; cur[1] = '0;
    drive_req();
    #1;
    chk("rst_read_req", local_read_req, 0);
    chk("rst_write_req", local_write_req, 0);
    chk("rst_burstbegin", local_burstbegin, 0);
    chk("rst_ack", {r0_ack, r1_ack}, 0);
    chk("rst_size", local_size, 3'b001);
    chk("rst_busy", busy, 0);
    chk("rst_orphan", err_orphan, 0);
    tick(); tick();
    wb_rst_i = 0;

    // bring-up: held read from r0 must wait for init_done
    r0_req = 1; r0_we = 0; r0_addr = 24'h000010;
    begin
      logic seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin tick(); seen |= r0_ack; end
      chk("init_no_ack", seen, 0);
    end
    init_done = 1;
    tick();
    chk("idle_entry_no_ack", r0_ack, 0);
    tick();
    chk("first_ack", r0_ack, 1);
    chk("first_read_req", local_read_req, 1);
    chk("first_write_req", local_write_req, 0);
    chk("first_addr", local_address, 24'h000010);
    chk("first_burst", local_burstbegin, 1);
    r0_req = 0;
    tick();
    chk("burst_drop", local_burstbegin, 0);
    chk("read_req_held", local_read_req, 1);
    chk("single_ack", r0_ack, 0);
    local_ready = 1;
    tick();
    chk("read_req_clear", local_read_req, 0);
    local_ready = 0; local_rdata_valid = 1; local_rdata = a5;
    tick();
    local_rdata_valid = 0;
    chk("ret_r0_rvalid", r0_rvalid, 1);
    chk("ret_r1_rvalid", r1_rvalid, 0);
    chk("ret_rdata", rdata, a5);
    tick();
    chk("rvalid_pulse", r0_rvalid, 0);

    // randomized traffic, then drain
    last_gnt = 0; prev_lreq = 0;
    run_model(3000, 1);
    run_model(300, 0);
    chk("drain_cmds", exp_q.size(), 0);
    chk("drain_reads", ret_q.size(), 0);
    chk("drain_r0", act[0], 0);
    chk("drain_r1", act[1], 0);
    drive_req();
    local_ready = 0; local_rdata_valid = 0;

    // reset mid-ISSUE with two reads outstanding
    r0_req = 1; r0_we = 0; r0_addr = 24'h000100;
    tick(); r0_req = 0; local_ready = 1;
    tick();
    r1_req = 1; r1_we = 0; r1_addr = 24'h000200;
    tick(); r1_req = 0;
    tick(); local_ready = 0;
    r0_req = 1; r0_we = 1; r0_be = 32'hFFFF0000;
    tick(); r0_req = 0;
    tick();
    chk("pre_rst_write_req", local_write_req, 1);
    chk("pre_rst_busy", busy, 1);
    #2 wb_rst_i = 1;
    #1;
    chk("async_write_req", local_write_req, 0);
    chk("async_be", local_be, 0);
    chk("async_busy", busy, 0);
    chk("async_size", local_size, 3'b001);
    tick();
    wb_rst_i = 0;
    local_rdata_valid = 1; local_rdata = a5;
    tick();
    chk("orphan1_rvalid", {r0_rvalid, r1_rvalid}, 0);
    tick();
    local_rdata_valid = 0;
    chk("orphan2_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("orphan_flag", err_orphan, 1);
    tick();
    chk("orphan_sticky", err_orphan, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
